// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator: owns the fetch PC, tracks the one-cycle memory
// response, absorbs decode stalls with a one-entry capture buffer and restarts on redirect.
module instr_fetch_unit #(
  parameter int unsigned            ADDR_W   = 12,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic [31:0]       fetch_count
);

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic              resp_valid;
  logic              hold_valid;
  logic [31:0]       hold_instr;
  logic              accept;
  logic              advance;

  assign accept  = resp_valid && !stall;
  assign advance = !stall || !resp_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= '0;
      resp_valid  <= 1'b0;
      hold_valid  <= 1'b0;
      hold_instr  <= '0;
      fetch_count <= '0;
    end else begin
      if (accept) fetch_count <= fetch_count + 32'd1;
      if (redirect_valid) begin
        fetch_pc   <= redirect_target;
        resp_valid <= 1'b0;
        hold_valid <= 1'b0;
      end else if (advance) begin
        resp_pc    <= fetch_pc;
        resp_valid <= 1'b1;
        fetch_pc   <= fetch_pc + ADDR_W'(1);
        hold_valid <= 1'b0;
      end else if (!hold_valid) begin
        // Memory moves on to fetch_pc during the stall; keep the word decode is looking at.
        hold_instr <= imem_data;
        hold_valid <= 1'b1;
      end
    end
  end

  assign imem_addr   = fetch_pc;
  assign instr_pc    = resp_pc;
  assign instr_valid = resp_valid;
  assign instr       = resp_valid ? (hold_valid ? hold_instr : imem_data) : 32'd0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed test-plan sequence then random stall/redirect/reset
// traffic, checked against an instruction-stream model where instr is always mem[instr_pc].
module tb_instr_fetch_unit;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset, stall, redirect_valid;
  logic [AW-1:0] redirect_target;
  logic [AW-1:0] imem_addr, imem_addr1, instr_pc, instr_pc1;
  logic [31:0]   imem_data, imem_data1, instr, instr1, fetch_count, fetch_count1;
  logic          instr_valid, instr_valid1;

  int vecs = 0;
  int errs = 0;

  // Reference model state: what decode should see, plus the next sequential fetch address.
  logic          m_v;
  logic [AW-1:0] m_pc, m_next;
  logic [31:0]   m_cnt;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(12'h000)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .fetch_count(fetch_count));

  instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(12'hFFE)) dut_wrap (
    .clk(clk), .reset(reset), .imem_addr(imem_addr1), .imem_data(imem_data1),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .instr(instr1), .instr_pc(instr_pc1), .instr_valid(instr_valid1), .fetch_count(fetch_count1));

  function automatic logic [31:0] mem(input logic [AW-1:0] a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  always @(posedge clk) begin
    imem_data  <= mem(imem_addr);
    imem_data1 <= mem(imem_addr1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic s, input logic rv, input logic [AW-1:0] t);
    if (r) begin
      m_v = 1'b0; m_pc = '0; m_cnt = '0; m_next = 12'h000;
    end else begin
      if (m_v && !s) m_cnt = m_cnt + 1;
      if (rv) begin
        m_v = 1'b0; m_next = t;
      end else if (!m_v || !s) begin
        m_pc = m_next; m_next = m_next + 1'b1; m_v = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("valid", 32'(instr_valid), 32'(m_v));
    chk("pc",    32'(instr_pc), 32'(m_pc));
    chk("instr", instr, m_v ? mem(m_pc) : 32'd0);
    chk("addr",  32'(imem_addr), 32'(m_next));
    chk("count", fetch_count, m_cnt);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check off-edge.
  task automatic step(input logic r, input logic s, input logic rv, input logic [AW-1:0] t);
    reset = r; stall = s; redirect_valid = rv; redirect_target = t;
    @(posedge clk);
    model_edge(r, s, rv, t);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [AW-1:0] wrap_seq [4];
    wrap_seq[0] = 12'hFFE; wrap_seq[1] = 12'hFFF; wrap_seq[2] = 12'h000; wrap_seq[3] = 12'h001;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    m_v = 1'b0; m_pc = '0; m_next = '0; m_cnt = '0;
    @(negedge clk);
    step(1, 0, 0, 0);
    chk("wrap_rst_addr", 32'(imem_addr1), 32'h0000_0FFE);
    chk("wrap_rst_valid", 32'(instr_valid1), 32'd0);

    // Free-run; the wrap instance sees the same inputs and must walk FFE, FFF, 000, 001.
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      chk("wrap_pc", 32'(instr_pc1), 32'(wrap_seq[i]));
      chk("wrap_instr", instr1, mem(wrap_seq[i]));
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("plan_pc5", 32'(instr_pc), 32'd5);

    // Stall three cycles on pc 5, release, expect 6 then 7.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      chk("stall_instr", instr, 32'h1000_0005);
    end
    step(0, 0, 0, 0);
    chk("release_pc6", 32'(instr_pc), 32'd6);
    step(0, 0, 0, 0);
    chk("release_pc7", 32'(instr_pc), 32'd7);

    // Redirect to 0x200 while showing 7: one bubble, then target.
    step(0, 0, 1, 12'h200);
    chk("redir_count", fetch_count, 32'd8);
    step(0, 0, 0, 0);
    chk("redir_instr", instr, 32'h1000_0200);
    step(0, 0, 0, 0);

    // Redirect together with stall: stalled instruction never accepted.
    step(0, 1, 0, 0);
    step(0, 1, 1, 12'h300);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 1, 12'h010);
    step(0, 0, 1, 12'h020);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Reset in the middle of a two-cycle stall.
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      logic          r, s, rv;
      logic [AW-1:0] t;
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 40);
      rv = ($urandom_range(0, 99) < 10);
      t  = AW'($urandom);
      if ($urandom_range(0, 7) == 0) t = 12'hFFF;
      step(r, s, rv, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
